// File: rtl/mac_result_drain.sv
// Drains the accumulators of a MAC row: snapshot on calc_done, clear the MACs,
// then stream each result word out over valid/ready. A new calculation may run
// in the MACs while the snapshot is still being streamed.

// One shadow register per MAC. It loads only on the capture edge.
module mac_shadow_lane #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Holds the snapshot until the next capture so the MAC can be reused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
  end
endmodule

module mac_result_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 3*DATA_WIDTH,
  parameter int NUM_MACS   = 8,
  parameter int IDX_W      = $clog2(NUM_MACS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          calc_done,
  input  logic [NUM_MACS*ACC_WIDTH-1:0] mac_couts,
  output logic                          mac_clr,
  output logic [ACC_WIDTH-1:0]          out_data,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_valid,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          overrun
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_STREAM  = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MACS-1);

  logic [1:0]                          state;
  logic [IDX_W-1:0]                    idx;
  logic [NUM_MACS-1:0][ACC_WIDTH-1:0]  shadow;
  logic                                load;
  logic                                streaming;
  logic                                hs;

  // Capture only from IDLE; a calc_done anywhere else is an overrun
  assign load      = (state == S_IDLE) && calc_done;
  assign streaming = (state == S_STREAM);
  assign hs        = streaming && out_ready;

  genvar g;
  generate
    for (g = 0; g < NUM_MACS; g++) begin : g_lane
      mac_shadow_lane #(.W(ACC_WIDTH)) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .d     (mac_couts[g*ACC_WIDTH +: ACC_WIDTH]),
        .q     (shadow[g])
      );
    end
  endgenerate

  // Sequencer: IDLE -> CAPTURE (one cycle, clears MACs) -> STREAM -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      mac_clr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (calc_done) begin
            state   <= S_CAPTURE;
            mac_clr <= 1'b1;
          end
        end
        S_CAPTURE: begin
          mac_clr <= 1'b0;
          idx     <= '0;
          state   <= S_STREAM;
        end
        S_STREAM: begin
          if (hs) begin
            if (idx == LAST_IDX) state <= S_IDLE;
            else                 idx   <= idx + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          mac_clr <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun flag; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             overrun <= 1'b0;
    else if (calc_done && state != S_IDLE) overrun <= 1'b1;
  end

  // Output word is gated so the bus reads zero whenever nothing is offered
  always_comb begin
    out_valid = streaming;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    if (streaming) begin
      out_data = shadow[idx];
      out_idx  = idx;
      out_last = (idx == LAST_IDX);
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed bench for mac_result_drain at default parameters (8 MACs, 24-bit).
module tb_mac_result_drain;
  localparam int N  = 8;
  localparam int AW = 24;
  localparam int IW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              calc_done;
  logic [N*AW-1:0]   mac_couts;
  logic              mac_clr;
  logic [AW-1:0]     out_data;
  logic [IW-1:0]     out_idx;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              overrun;

  int total = 0;
  int bad   = 0;

  mac_result_drain dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .calc_done (calc_done),
    .mac_couts (mac_couts),
    .mac_clr   (mac_clr),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Stimulus helpers (drive only)
  task automatic set_couts(input logic [AW-1:0] base, input logic [AW-1:0] step);
    for (int i = 0; i < N; i++) mac_couts[i*AW +: AW] = base + AW'(i) * step;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; calc_done = 1'b0; out_ready = 1'b0; mac_couts = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; calc_done = 1'b0; out_ready = 1'b0; mac_couts = '0;
    @(negedge clk);
    total++;
    if ({mac_clr, out_valid, out_last, busy, overrun} !== 5'b0 || out_data !== '0 || out_idx !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got clr=%b v=%b l=%b busy=%b ovr=%b data=%h idx=%0d want all 0",
               mac_clr, out_valid, out_last, busy, overrun, out_data, out_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_idle: busy=%b valid=%b want 0 0", busy, out_valid);
    end
  endtask

  // MAC i = i*100, ready always high
  task automatic test_basic_stream();
    set_couts(24'd0, 24'd100);
    out_ready = 1'b1;
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    total++;
    if (mac_clr !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_capture: clr=%b valid=%b busy=%b want 1 0 1", mac_clr, out_valid, busy);
    end
    @(negedge clk);
    total++;
    if (mac_clr !== 1'b0) begin
      bad++; $display("FAIL basic_clr_width: clr=%b want 0", mac_clr);
    end
    for (int k = 0; k < N; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_idx !== IW'(k) || out_data !== AW'(k*100) || out_last !== (k == N-1)) begin
        bad++;
        $display("FAIL basic_word%0d: v=%b idx=%0d data=%0d last=%b want 1 %0d %0d %b",
                 k, out_valid, out_idx, out_data, out_last, k, k*100, (k == N-1));
      end
      @(negedge clk);
    end
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL basic_end: v=%b last=%b busy=%b ovr=%b want 0 0 0 0", out_valid, out_last, busy, overrun);
    end
  endtask

  // Ready pattern 1,0,0 repeating; each word must hold until accepted
  task automatic test_backpressure();
    int exp_i;
    int cyc;
    set_couts(24'd0, 24'd100);
    out_ready = 1'b0;
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    @(negedge clk);
    exp_i = 0;
    cyc = 0;
    while (exp_i < N && cyc < 60) begin
      total++;
      if (out_valid !== 1'b1 || out_idx !== IW'(exp_i) || out_data !== AW'(exp_i*100)) begin
        bad++;
        $display("FAIL bp_cycle%0d: v=%b idx=%0d data=%0d want 1 %0d %0d", cyc, out_valid, out_idx, out_data, exp_i, exp_i*100);
      end
      out_ready = (cyc % 3 == 0);
      if (out_ready) exp_i++;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    total++;
    if (exp_i != N || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_done: words=%0d valid=%b want %0d 0", exp_i, out_valid, N);
    end
  endtask

  // Inputs changing after capture must not leak; full scale passes intact
  task automatic test_capture_isolation();
    set_couts(24'd0, 24'd100);
    out_ready = 1'b1;
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    set_couts(24'hFFFFFF, 24'd0);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== AW'(k*100)) begin
        bad++; $display("FAIL iso_word%0d: v=%b data=%h want 1 %h", k, out_valid, out_data, AW'(k*100));
      end
      @(negedge clk);
    end
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 24'hFFFFFF || out_idx !== IW'(k)) begin
        bad++; $display("FAIL fullscale_word%0d: v=%b data=%h idx=%0d want 1 ffffff %0d", k, out_valid, out_data, out_idx, k);
      end
      @(negedge clk);
    end
  endtask

  // calc_done mid-stream: flag overrun, no recapture, no extra clear
  task automatic test_overrun();
    set_couts(24'd5, 24'd3);
    out_ready = 1'b1;
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    set_couts(24'd999, 24'd1);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      calc_done = (k == 3);
      total++;
      if (out_valid !== 1'b1 || out_data !== AW'(5 + 3*k) || mac_clr !== 1'b0) begin
        bad++; $display("FAIL ovr_word%0d: v=%b data=%0d clr=%b want 1 %0d 0", k, out_valid, out_data, mac_clr, 5 + 3*k);
      end
      if (k == 5) begin
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: overrun=%b want 1", overrun); end
      end
      @(negedge clk);
    end
    calc_done = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (overrun !== 1'b1 || busy !== 1'b0 || mac_clr !== 1'b0) begin
      bad++; $display("FAIL ovr_sticky: ovr=%b busy=%b clr=%b want 1 0 0", overrun, busy, mac_clr);
    end
  endtask

  // calc_done on the final handshake: overrun, back to IDLE, no capture
  task automatic test_last_overlap();
    do_reset();
    set_couts(24'd1, 24'd1);
    out_ready = 1'b1;
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    @(negedge clk);
    repeat (N-1) @(negedge clk);
    total++;
    if (out_last !== 1'b1 || out_data !== 24'd8) begin
      bad++; $display("FAIL overlap_last: last=%b data=%0d want 1 8", out_last, out_data);
    end
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    total++;
    if (overrun !== 1'b1 || busy !== 1'b0 || mac_clr !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL overlap_idle: ovr=%b busy=%b clr=%b v=%b want 1 0 0 0", overrun, busy, mac_clr, out_valid);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL overlap_nocap: busy=%b v=%b want 0 0", busy, out_valid);
    end
  endtask

  // Reset mid-stream aborts; next calc_done restarts at index 0
  task automatic test_reset_midstream();
    set_couts(24'd10, 24'd10);
    out_ready = 1'b1;
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    @(negedge clk);
    repeat (5) @(negedge clk);
    total++;
    if (out_idx !== 3'd5 || out_data !== 24'd60) begin
      bad++; $display("FAIL rst_pre: idx=%0d data=%0d want 5 60", out_idx, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({mac_clr, out_valid, out_last, busy, overrun} !== 5'b0 || out_data !== '0 || out_idx !== '0) begin
      bad++;
      $display("FAIL rst_async: clr=%b v=%b l=%b busy=%b ovr=%b data=%h idx=%0d want all 0",
               mac_clr, out_valid, out_last, busy, overrun, out_data, out_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_couts(24'd7, 24'd2);
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_data !== 24'd7) begin
      bad++; $display("FAIL rst_fresh: v=%b idx=%0d data=%0d want 1 0 7", out_valid, out_idx, out_data);
    end
    repeat (N) @(negedge clk);
  endtask

  // Two bursts spaced NUM_MACS+2 cycles apart: two clears, no overrun
  task automatic test_back_to_back();
    int clr_cnt;
    int words;
    do_reset();
    clr_cnt = 0;
    words = 0;
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      set_couts(AW'(b*1000), 24'd7);
      calc_done = 1'b1;
      @(negedge clk);
      calc_done = 1'b0;
      for (int c = 0; c < N + 1; c++) begin
        if (mac_clr === 1'b1) clr_cnt++;
        if (out_valid === 1'b1) begin
          total++;
          if (out_data !== AW'(b*1000 + 7*words) || out_idx !== IW'(words)) begin
            bad++; $display("FAIL b2b_b%0d_w%0d: data=%0d idx=%0d want %0d %0d",
                            b, words, out_data, out_idx, b*1000 + 7*words, words);
          end
          words++;
        end
        @(negedge clk);
      end
      words = 0;
    end
    total++;
    if (clr_cnt != 2 || overrun !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_summary: clr=%0d ovr=%b busy=%b want 2 0 0", clr_cnt, overrun, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; calc_done = 1'b0; out_ready = 1'b0; mac_couts = '0;
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_capture_isolation();
    test_overrun();
    test_last_overlap();
    test_reset_midstream();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
